// File: rtl/mem_arbiter.sv
// Two-requester (instruction/data) arbiter onto a single shared memory bus.
// One transaction in flight at a time; D has priority, but I is forced in after STARVE_MAX D wins.
module mem_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_valid,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ok,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_valid,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic                d_write,
  input  logic [DATA_W/8-1:0] d_strobe,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ok,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_addr,
  output logic                m_write,
  output logic [DATA_W/8-1:0] m_strobe,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_ok,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             i_starved;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  assign i_starved = i_valid && (starve_cnt == CNT_MAX);

  // The m_* outputs double as the latched request registers, so the bus sees
  // only values captured when leaving IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      m_valid    <= 1'b0;
      m_addr     <= '0;
      m_write    <= 1'b0;
      m_strobe   <= '0;
      m_wdata    <= '0;
      i_ok       <= 1'b0;
      d_ok       <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      i_ok <= 1'b0;
      d_ok <= 1'b0;
      case (state)
        IDLE: begin
          if (d_valid && !i_starved) begin
            state    <= GRANT_D;
            m_valid  <= 1'b1;
            m_addr   <= d_addr;
            m_write  <= d_write;
            m_strobe <= d_strobe;
            m_wdata  <= d_wdata;
            if (i_valid) starve_cnt <= sat_inc(starve_cnt);
          end else if (i_valid) begin
            state      <= GRANT_I;
            m_valid    <= 1'b1;
            m_addr     <= i_addr;
            m_write    <= 1'b0;
            m_strobe   <= '0;
            m_wdata    <= '0;
            starve_cnt <= '0;
          end
        end
        GRANT_I: begin
          if (m_ok) begin
            state   <= RESP;
            m_valid <= 1'b0;
            i_rdata <= m_rdata;
            i_ok    <= 1'b1;
          end
        end
        GRANT_D: begin
          if (m_ok) begin
            state   <= RESP;
            m_valid <= 1'b0;
            d_rdata <= m_rdata;
            d_ok    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// transaction-level run against an arbitration model.
module tb_mem_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int SMAX = 4;

  logic          clk, reset;
  logic          i_valid, i_ok, d_valid, d_write, d_ok, m_valid, m_write, m_ok;
  logic [AW-1:0] i_addr, d_addr, m_addr;
  logic [DW-1:0] i_rdata, d_rdata, d_wdata, m_wdata, m_rdata;
  logic [7:0]    d_strobe, m_strobe;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_i_rdata, exp_d_rdata;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_addr(i_addr), .i_ok(i_ok), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_addr(d_addr), .d_write(d_write), .d_strobe(d_strobe),
    .d_wdata(d_wdata), .d_ok(d_ok), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_addr(m_addr), .m_write(m_write), .m_strobe(m_strobe),
    .m_wdata(m_wdata), .m_ok(m_ok), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_valid = 0; i_addr = '0; d_valid = 0; d_addr = '0; d_write = 0;
    d_strobe = '0; d_wdata = '0; m_ok = 0; m_rdata = '0;
  endtask

  task automatic test_reset();
    reset = 1;
    idle_inputs();
    tick(); tick();
    n_cmp++;
    if ({m_valid, m_addr, m_write, m_strobe, m_wdata, i_ok, d_ok, i_rdata, d_rdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: m_valid=%0b m_addr=%h i_ok=%0b d_ok=%0b i_rdata=%h d_rdata=%h required all zero",
               m_valid, m_addr, i_ok, d_ok, i_rdata, d_rdata);
    end
    reset = 0;
    exp_i_rdata = '0; exp_d_rdata = '0;
    tick();
  endtask

  task automatic test_i_only();
    i_valid = 1; i_addr = 64'h8000_0000;
    tick();
    n_cmp++;
    if ({m_valid, m_addr, m_write, d_ok} !== {1'b1, 64'h8000_0000, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL i_only_grant: m_valid=%0b m_addr=%h m_write=%0b d_ok=%0b required 1 80000000 0 0",
               m_valid, m_addr, m_write, d_ok);
    end
    i_valid = 0; m_ok = 1; m_rdata = 64'h13;
    tick();
    m_ok = 0;
    exp_i_rdata = 64'h13;
    n_cmp++;
    if ({i_ok, i_rdata, d_ok, m_valid} !== {1'b1, exp_i_rdata, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL i_only_resp: i_ok=%0b i_rdata=%h d_ok=%0b m_valid=%0b required 1 13 0 0",
               i_ok, i_rdata, d_ok, m_valid);
    end
    tick();
    n_cmp++;
    if ({i_ok, d_ok} !== 2'b00) begin
      n_bad++;
      $display("FAIL i_only_pulse: i_ok=%0b d_ok=%0b required 0 0", i_ok, d_ok);
    end
  endtask

  task automatic test_simultaneous();
    i_valid = 1; i_addr = 64'h4000;
    d_valid = 1; d_addr = 64'h100; d_write = 1; d_strobe = 8'hFF; d_wdata = 64'hAB;
    tick();
    n_cmp++;
    if ({m_valid, m_addr, m_write, m_strobe, m_wdata} !== {1'b1, 64'h100, 1'b1, 8'hFF, 64'hAB}) begin
      n_bad++;
      $display("FAIL simul_d_first: m_valid=%0b m_addr=%h m_write=%0b m_strobe=%h m_wdata=%h required 1 100 1 ff ab",
               m_valid, m_addr, m_write, m_strobe, m_wdata);
    end
    d_valid = 0; m_ok = 1; m_rdata = 64'h0;
    tick();
    m_ok = 0;
    exp_d_rdata = 64'h0;
    n_cmp++;
    if ({d_ok, i_ok} !== 2'b10) begin
      n_bad++;
      $display("FAIL simul_d_ok: d_ok=%0b i_ok=%0b required 1 0", d_ok, i_ok);
    end
    tick();
    n_cmp++;
    if ({m_valid, d_ok, i_ok} !== 3'b000) begin
      n_bad++;
      $display("FAIL simul_idle: m_valid=%0b d_ok=%0b i_ok=%0b required 0 0 0", m_valid, d_ok, i_ok);
    end
    tick();
    n_cmp++;
    if ({m_valid, m_addr, m_write, m_strobe} !== {1'b1, 64'h4000, 1'b0, 8'h00}) begin
      n_bad++;
      $display("FAIL simul_i_next: m_valid=%0b m_addr=%h m_write=%0b m_strobe=%h required 1 4000 0 00",
               m_valid, m_addr, m_write, m_strobe);
    end
    i_valid = 0; m_ok = 1; m_rdata = 64'h21;
    tick();
    m_ok = 0;
    exp_i_rdata = 64'h21;
    n_cmp++;
    if ({i_ok, i_rdata, d_ok} !== {1'b1, exp_i_rdata, 1'b0}) begin
      n_bad++;
      $display("FAIL simul_i_ok: i_ok=%0b i_rdata=%h d_ok=%0b required 1 %h 0", i_ok, i_rdata, d_ok, exp_i_rdata);
    end
    tick();
  endtask

  task automatic test_starvation();
    byte seq [10];
    int  grants = 0;
    i_valid = 1; i_addr = 64'h1000;
    d_valid = 1; d_addr = 64'h2000; d_write = 0; d_strobe = '0; d_wdata = '0;
    m_ok = 1; m_rdata = 64'h77;
    for (int c = 0; c < 60 && grants < 10; c++) begin
      tick();
      if (m_valid) begin
        seq[grants] = (m_addr == 64'h2000) ? "D" : "I";
        grants++;
        if (grants == 10) begin
          i_valid = 0; d_valid = 0;
        end
      end
    end
    n_cmp++;
    if (grants !== 10) begin
      n_bad++;
      $display("FAIL starve_grant_count: got %0d grants required 10", grants);
    end
    for (int g = 0; g < grants; g++) begin
      n_cmp++;
      if (seq[g] !== ((g % 5 == 4) ? "I" : "D")) begin
        n_bad++;
        $display("FAIL starve_seq[%0d]: got %c required %c", g, seq[g], (g % 5 == 4) ? "I" : "D");
      end
    end
    tick();
    m_ok = 0;
    exp_i_rdata = 64'h77; exp_d_rdata = 64'h77;
    tick();
  endtask

  task automatic test_slow_bus();
    d_valid = 1; d_addr = 64'h200; d_write = 0; i_valid = 0; m_ok = 0;
    tick();
    for (int j = 1; j <= 6; j++) begin
      n_cmp++;
      if ({m_valid, m_addr, m_write, d_ok} !== {1'b1, 64'h200, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL slow_hold[%0d]: m_valid=%0b m_addr=%h m_write=%0b d_ok=%0b required 1 200 0 0",
                 j, m_valid, m_addr, m_write, d_ok);
      end
      d_valid = 0; d_addr = {$urandom, $urandom}; d_write = 1;
      m_ok = (j == 6); m_rdata = 64'h5A5A;
      tick();
    end
    m_ok = 0;
    exp_d_rdata = 64'h5A5A;
    n_cmp++;
    if ({d_ok, d_rdata, i_ok} !== {1'b1, exp_d_rdata, 1'b0}) begin
      n_bad++;
      $display("FAIL slow_d_ok: d_ok=%0b d_rdata=%h i_ok=%0b required 1 %h 0", d_ok, d_rdata, i_ok, exp_d_rdata);
    end
    tick();
  endtask

  task automatic test_reset_during_grant();
    d_valid = 1; d_addr = 64'h300; d_write = 1; d_strobe = 8'h0F; d_wdata = 64'h99;
    i_valid = 1; i_addr = 64'h400;
    tick();
    n_cmp++;
    if ({m_valid, m_addr} !== {1'b1, 64'h300}) begin
      n_bad++;
      $display("FAIL rst_pre_grant: m_valid=%0b m_addr=%h required 1 300", m_valid, m_addr);
    end
    #3 reset = 1;
    #1;
    n_cmp++;
    if ({m_valid, m_addr, m_write, m_strobe, m_wdata, d_ok, d_rdata, i_rdata} !== '0) begin
      n_bad++;
      $display("FAIL rst_async: m_valid=%0b m_addr=%h d_ok=%0b d_rdata=%h i_rdata=%h required all zero",
               m_valid, m_addr, d_ok, d_rdata, i_rdata);
    end
    n_cmp++;
    if (dut.starve_cnt !== '0) begin
      n_bad++;
      $display("FAIL rst_starve_cnt: got %0d required 0", dut.starve_cnt);
    end
    i_valid = 0; d_valid = 0; m_ok = 1; m_rdata = 64'hDEAD;
    tick();
    reset = 0; m_ok = 0;
    exp_i_rdata = '0; exp_d_rdata = '0;
    i_valid = 1; i_addr = 64'h400;
    n_cmp++;
    if ({d_ok, i_ok, m_valid} !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_release_idle: d_ok=%0b i_ok=%0b m_valid=%0b required 0 0 0", d_ok, i_ok, m_valid);
    end
    tick();
    n_cmp++;
    if ({m_valid, m_addr, m_write, d_ok} !== {1'b1, 64'h400, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL rst_fresh_grant: m_valid=%0b m_addr=%h m_write=%0b d_ok=%0b required 1 400 0 0",
               m_valid, m_addr, m_write, d_ok);
    end
    i_valid = 0; m_ok = 1; m_rdata = 64'h55;
    tick();
    m_ok = 0;
    exp_i_rdata = 64'h55;
    n_cmp++;
    if ({i_ok, i_rdata, d_ok, d_rdata} !== {1'b1, exp_i_rdata, 1'b0, exp_d_rdata}) begin
      n_bad++;
      $display("FAIL rst_fresh_done: i_ok=%0b i_rdata=%h d_ok=%0b d_rdata=%h required 1 55 0 0",
               i_ok, i_rdata, d_ok, d_rdata);
    end
    tick();
  endtask

  task automatic test_spurious_ok();
    idle_inputs();
    m_ok = 1; m_rdata = 64'hFFFF;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if ({i_ok, d_ok, m_valid, i_rdata, d_rdata} !== {3'b000, exp_i_rdata, exp_d_rdata}) begin
        n_bad++;
        $display("FAIL spurious[%0d]: i_ok=%0b d_ok=%0b m_valid=%0b i_rdata=%h d_rdata=%h required 0 0 0 %h %h",
                 c, i_ok, d_ok, m_valid, i_rdata, d_rdata, exp_i_rdata, exp_d_rdata);
      end
    end
    m_ok = 0;
    tick();
  endtask

  // Transaction-level model: each IDLE decision picks a winner from the
  // requester pattern and the running count of D wins over a waiting I.
  task automatic test_random();
    int            cnt = 0;
    int            win;
    int            k;
    logic [AW-1:0] ea;
    logic          ew;
    logic [7:0]    es;
    logic [DW-1:0] ewd, rd;
    reset = 1; idle_inputs();
    tick();
    reset = 0;
    exp_i_rdata = '0; exp_d_rdata = '0;
    for (int t = 0; t < 300; t++) begin
      n_cmp++;
      if ({m_valid, i_ok, d_ok} !== 3'b000) begin
        n_bad++;
        $display("FAIL rnd_idle[%0d]: m_valid=%0b i_ok=%0b d_ok=%0b required 0 0 0", t, m_valid, i_ok, d_ok);
      end
      i_valid = ($urandom % 4) != 0; i_addr = {$urandom, $urandom};
      d_valid = ($urandom % 4) != 0; d_addr = {$urandom, $urandom};
      d_write = $urandom % 2; d_strobe = 8'($urandom); d_wdata = {$urandom, $urandom};
      m_ok = $urandom % 2; m_rdata = {$urandom, $urandom};
      win = 0;
      if (d_valid && !(i_valid && cnt == SMAX)) begin
        win = 2; ea = d_addr; ew = d_write; es = d_strobe; ewd = d_wdata;
        if (i_valid && cnt < SMAX) cnt = cnt + 1;
      end else if (i_valid) begin
        win = 1; ea = i_addr; ew = 0; es = '0; ewd = '0;
        cnt = 0;
      end
      tick();
      if (win == 0) continue;
      k = $urandom_range(1, 4);
      rd = '0;
      for (int j = 1; j <= k; j++) begin
        n_cmp++;
        if ({m_valid, m_addr, m_write, m_strobe, i_ok, d_ok} !== {1'b1, ea, ew, es, 2'b00}) begin
          n_bad++;
          $display("FAIL rnd_grant[%0d.%0d]: m_valid=%0b m_addr=%h m_write=%0b m_strobe=%h required 1 %h %0b %h",
                   t, j, m_valid, m_addr, m_write, m_strobe, ea, ew, es);
        end
        if (win == 2) begin
          n_cmp++;
          if (m_wdata !== ewd) begin
            n_bad++;
            $display("FAIL rnd_wdata[%0d.%0d]: m_wdata=%h required %h", t, j, m_wdata, ewd);
          end
        end
        i_valid = $urandom % 2; i_addr = {$urandom, $urandom};
        d_valid = $urandom % 2; d_addr = {$urandom, $urandom};
        d_write = $urandom % 2; d_strobe = 8'($urandom); d_wdata = {$urandom, $urandom};
        rd = {$urandom, $urandom};
        m_ok = (j == k); m_rdata = rd;
        tick();
      end
      if (win == 1) exp_i_rdata = rd;
      else exp_d_rdata = rd;
      n_cmp++;
      if ({i_ok, d_ok, i_rdata, d_rdata} !== {win == 1, win == 2, exp_i_rdata, exp_d_rdata}) begin
        n_bad++;
        $display("FAIL rnd_resp[%0d]: i_ok=%0b d_ok=%0b i_rdata=%h d_rdata=%h required %0b %0b %h %h",
                 t, i_ok, d_ok, i_rdata, d_rdata, win == 1, win == 2, exp_i_rdata, exp_d_rdata);
      end
      m_ok = $urandom % 2; m_rdata = {$urandom, $urandom};
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_i_only();
    test_simultaneous();
    test_starvation();
    test_slow_bus();
    test_reset_during_grant();
    test_spurious_ok();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 64, address width of all request paths.
REQ-002 The block SHALL have parameter DATA_W, default 64, data width of all read/write paths.
REQ-003 The block SHALL have parameter STARVE_MAX, default 4, the maximum number of consecutive D grants while I is pending.
REQ-004 The block SHALL have one clock and asynchronous active-high reset: clk  in  1  clock; reset  in  1  async active-high reset.
REQ-005 The block SHALL have these instruction-port signals: i_valid in 1 fetch request; i_addr in ADDR_W fetch address; i_ok out 1 completion pulse; i_rdata out DATA_W fetch data.
REQ-006 The block SHALL have these data-port signals: d_valid in 1 request; d_addr in ADDR_W address; d_write in 1 store when 1; d_strobe in DATA_W/8 byte enables; d_wdata in DATA_W store data; d_ok out 1 completion pulse; d_rdata out DATA_W load data.
REQ-007 The block SHALL have these shared-bus signals: m_valid out 1 request; m_addr out ADDR_W; m_write out 1; m_strobe out DATA_W/8; m_wdata out DATA_W; m_ok in 1 transaction done; m_rdata in DATA_W.

Function
REQ-008 The block SHALL implement FSM states IDLE, GRANT_I, GRANT_D and RESP, and SHALL serve exactly one transaction at a time.
REQ-009 In IDLE, the block SHALL go to GRANT_D if d_valid=1 and NOT (i_valid=1 and starve_cnt==STARVE_MAX); else it SHALL go to GRANT_I if i_valid=1; else it SHALL stay in IDLE.
REQ-010 On leaving IDLE, the block SHALL latch the winner's addr/write/strobe/wdata into internal registers; for I grants, write=0 and strobe=0.
REQ-011 In GRANT_x, m_valid SHALL be 1 and m_addr/m_write/m_strobe/m_wdata SHALL be driven only from the latched registers, held stable regardless of requester inputs.
REQ-012 In GRANT_x on m_ok=1, the block SHALL capture m_rdata into x_rdata and go to RESP; otherwise it SHALL stay in GRANT_x with no timeout.
REQ-013 In RESP, x_ok SHALL be 1 for exactly one cycle for the granted requester only, and the FSM SHALL return to IDLE.
REQ-014 Requester inputs sampled in IDLE SHALL be treated as a new request, and requesters SHALL be allowed to drop valid while their transaction is in flight without affecting it.
REQ-015 Latency SHALL be: request seen in IDLE at cycle N gives m_valid at N+1, and m_ok at N+k (k>=1) gives x_ok at N+k+1; back-to-back throughput SHALL be one transaction per k+2 cycles.
REQ-016 starve_cnt SHALL increment, saturating at STARVE_MAX, on every D grant made while i_valid=1, and SHALL clear to 0 on every I grant; a D grant with i_valid=0 SHALL leave it unchanged.
REQ-017 m_ok SHALL be ignored in IDLE and RESP, and m_rdata SHALL be captured only per REQ-012.
REQ-018 x_rdata SHALL hold its value until the next completion for that same requester.
REQ-019 All outputs SHALL be registered or decoded from state only, with no combinational path from m_ok or requester inputs to any output.

Reset
REQ-020 While reset=1, state SHALL be IDLE, starve_cnt SHALL be 0, latched request registers SHALL be 0, and m_valid, m_addr, m_write, m_strobe, m_wdata, i_ok, d_ok, i_rdata and d_rdata SHALL all be 0, applied asynchronously.
REQ-021 Reset asserted mid-transaction SHALL abandon it with no x_ok emitted, and the first cycle after deassertion SHALL behave as IDLE.

Verification
REQ-022 The bench SHALL cover I only: i_valid=1, i_addr=0x80000000 at cycle 0, m_ok=1 with m_rdata=0x13 at cycle 1 -> m_valid=1, m_addr=0x80000000, m_write=0 at cycle 1; i_ok=1, i_rdata=0x13 at cycle 2; d_ok=0 throughout.
REQ-023 The bench SHALL cover a simultaneous request with starve_cnt=0: d_valid (store, addr 0x100, strobe 0xFF, wdata 0xAB) and i_valid both at cycle 0 -> D served first with m_write=1 and m_wdata=0xAB; then I granted in the IDLE cycle after d_ok.
REQ-024 The bench SHALL cover starvation: i_valid and d_valid held high, m_ok=1 on every GRANT cycle, STARVE_MAX=4 -> grant sequence D,D,D,D,I,D,D,D,D,I.
REQ-025 The bench SHALL cover a slow bus: D load at addr 0x200, m_ok delayed 5 cycles, d_valid dropped after cycle 1 -> m_valid/m_addr stable at 0x200 for 5 cycles; d_ok one cycle after m_ok.
REQ-026 The bench SHALL cover reset during GRANT_D: reset=1 mid-cycle -> m_valid=0 immediately; no d_ok ever; starve_cnt=0; a fresh I request after release completes normally.
REQ-027 The bench SHALL cover a spurious m_ok=1 with m_rdata=0xFFFF in IDLE -> no i_ok/d_ok; i_rdata/d_rdata unchanged.
